// File: rtl/counter_sched_if.sv
// Bundle between counter_sched and the requesters plus the external up-counter it drives.
// req is a level held by the requester; gnt stays high for the run, and done pulses once when the run ends.
interface counter_sched_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [WIDTH-1:0] count;
    logic             cnt_reset;
    logic             cnt_enable;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             err;
    logic [1:0]       state_dbg;

    modport master (
        output req, len0, len1, count,
        input  cnt_reset, cnt_enable, gnt, done, busy, err, state_dbg
    );

    modport slave (
        input  req, len0, len1, count,
        output cnt_reset, cnt_enable, gnt, done, busy, err, state_dbg
    );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler that gives one of two requesters a timed run of an external counter.
// Optional macro COUNTER_SCHED_CHECK_EN adds a count-vs-len check in DONE, reported on err.
module counter_sched #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             reset,
    counter_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             cnt_enable_q, cnt_enable_d;
    logic             busy_q, busy_d;
    logic             pick;

    always_comb begin
        // On a tie the requester that was not served last wins.
        pick         = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        state_d      = state_q;
        remaining_d  = remaining_q;
        last_d       = last_q;
        win_d        = win_q;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d     = CLEAR;
                    win_d       = pick;
                    remaining_d = pick ? bus.len1 : bus.len0;
                end
            end
            CLEAR: begin
                state_d = (remaining_q != '0) ? RUN : DONE;
            end
            RUN: begin
                remaining_d = remaining_q - WIDTH'(1);
                if (remaining_q == WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            state_d     = IDLE;
            remaining_d = '0;
            last_d      = 1'b1;
            win_d       = 1'b0;
        end

        gnt_d        = ((state_d == CLEAR) || (state_d == RUN)) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
        done_d       = (state_d == DONE) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
        cnt_reset_d  = (state_d == CLEAR);
        cnt_enable_d = (state_d == RUN);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        remaining_q  <= remaining_d;
        last_q       <= last_d;
        win_q        <= win_d;
        gnt_q        <= gnt_d;
        done_q       <= done_d;
        cnt_reset_q  <= cnt_reset_d;
        cnt_enable_q <= cnt_enable_d;
        busy_q       <= busy_d;
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.cnt_reset  = cnt_reset_q;
    assign bus.cnt_enable = cnt_enable_q;
    assign bus.busy       = busy_q;
    assign bus.state_dbg  = state_q;

`ifdef COUNTER_SCHED_CHECK_EN
    // remaining has counted down to zero by DONE, so the granted length is kept separately.
    logic [WIDTH-1:0] len_q, len_d;

    always_comb begin
        len_d = len_q;
        if ((state_q == IDLE) && (bus.req != 2'b00)) begin
            len_d = pick ? bus.len1 : bus.len0;
        end
        if (reset) begin
            len_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    assign bus.err = (state_q == DONE) && (bus.count != len_q);
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: drives requests, models the external counter, and scores
// each completed run (grant, done, count, enable cycles, err) against hand-computed entries.
module tb_counter_sched;
  localparam int W  = 4;
  localparam int EW = 13;
`ifdef COUNTER_SCHED_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  counter_sched_if #(.WIDTH(W)) bus ();
  counter_sched #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // external up-counter model; stuck mode ignores enable
  logic         stuck = 1'b0;
  logic [W-1:0] cnt_q = '0;
  always @(posedge clk) begin
    if (stuck) cnt_q <= '0;
    else if (bus.cnt_reset) cnt_q <= '0;
    else if (bus.cnt_enable) cnt_q <= cnt_q + W'(1);
  end
  assign bus.count = cnt_q;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  logic [W-1:0] en_cnt = '0;
  logic [1:0]   run_gnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] g, input logic [W-1:0] c,
                                       input logic [W-1:0] en, input logic er);
    return {g, g, c, en, er};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      en_cnt  = '0;
      run_gnt = '0;
    end else begin
      if (bus.cnt_reset) begin
        en_cnt  = '0;
        run_gnt = bus.gnt;
      end
      if (bus.cnt_enable) en_cnt = en_cnt + W'(1);
      check("onehot", {31'd0, ($countones(bus.gnt) <= 1) && ($countones(bus.done) <= 1)}, 32'd1);
      if (bus.done != 2'b00) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", {30'd0, bus.done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("run_result", {19'd0, run_gnt, bus.done, bus.count, en_cnt, bus.err}, {19'd0, e});
          check("gnt_low_in_done", {30'd0, bus.gnt}, 32'd0);
        end
      end
    end
  end

  task automatic wait_done(input int target, input string name);
    int cyc = 0;
    while (done_seen < target && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (done_seen < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done pulses %0d expected %0d", name, done_seen, target);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int cyc;
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {22'd0, bus.gnt, bus.done, bus.cnt_reset, bus.cnt_enable,
                            bus.busy, bus.err, bus.state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // single request, len 5
    bus.len0 = W'(5);
    bus.req  = 2'b01;
    exp_q.push_back(mk(2'b01, W'(5), W'(5), 1'b0));
    t = done_seen + 1;
    @(negedge clk);
    check("grant_edge", {27'd0, bus.gnt, bus.cnt_reset, bus.cnt_enable, bus.busy}, 32'b01101);
    @(negedge clk);
    check("first_enable", {30'd0, bus.cnt_reset, bus.cnt_enable}, 32'b01);
    wait_done(t, "len5");
    bus.req = 2'b00;

    // held tie, alternating grants starting at requester 0
    pulse_reset();
    bus.len0 = W'(3);
    bus.len1 = W'(2);
    bus.req  = 2'b11;
    exp_q.push_back(mk(2'b01, W'(3), W'(3), 1'b0));
    exp_q.push_back(mk(2'b10, W'(2), W'(2), 1'b0));
    exp_q.push_back(mk(2'b01, W'(3), W'(3), 1'b0));
    exp_q.push_back(mk(2'b10, W'(2), W'(2), 1'b0));
    t = done_seen + 1;
    wait_done(t, "tie_first");
    @(negedge clk);
    check("idle_gap_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("regrant_after_gap", {29'd0, bus.cnt_reset, bus.gnt}, 32'b110);
    wait_done(t + 3, "tie_rest");
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // zero length for requester 1
    bus.len1 = '0;
    bus.req  = 2'b10;
    exp_q.push_back(mk(2'b10, W'(0), W'(0), 1'b0));
    t = done_seen + 1;
    wait_done(t, "len0_zero");
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // maximum length
    bus.len0 = W'(15);
    bus.req  = 2'b01;
    exp_q.push_back(mk(2'b01, W'(15), W'(15), 1'b0));
    t = done_seen + 1;
    wait_done(t, "len_max");
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // reset during the third RUN cycle abandons the run
    bus.len0 = W'(8);
    bus.req  = 2'b01;
    cyc = 0;
    while (en_cnt != W'(3) && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("reached_run3", {28'd0, en_cnt}, 32'd3);
    reset   = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    check("reset_abort", {26'd0, bus.gnt, bus.cnt_enable, bus.busy, bus.done}, 32'd0);
    reset = 1'b0;
    bus.len0 = W'(2);
    bus.len1 = W'(3);
    bus.req  = 2'b11;
    exp_q.push_back(mk(2'b01, W'(2), W'(2), 1'b0));
    t = done_seen + 1;
    wait_done(t, "after_reset_tie");
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // counter stuck at 0: err only when the check is built in
    stuck    = 1'b1;
    bus.len0 = W'(4);
    bus.req  = 2'b01;
    exp_q.push_back(mk(2'b01, W'(0), W'(4), ERR_EXP));
    t = done_seen + 1;
    wait_done(t, "stuck_counter");
    bus.req = 2'b00;
    stuck   = 1'b0;

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
